// File: rtl/md5_pkg.sv
// Shared MD5 constants, state encoding and per-step helper functions
// used by the md5_stream engine and its md5_step datapath.
package md5_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } md5_state_e;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    localparam logic [31:0] K_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    localparam logic [4:0] S_TAB [64] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
    };

    function automatic logic [31:0] md5_f(input logic [1:0] round,
                                          input logic [31:0] b,
                                          input logic [31:0] c,
                                          input logic [31:0] d);
        logic [31:0] r;
        case (round)
            2'd0:    r = (b & c) | (~b & d);
            2'd1:    r = (b & d) | (c & ~d);
            2'd2:    r = b ^ c ^ d;
            default: r = c ^ (b | ~d);
        endcase
        return r;
    endfunction

    // Only the low nibble matters: every multiplier is reduced mod 16.
    function automatic logic [3:0] md5_g(input logic [5:0] i);
        logic [3:0] lo;
        logic [3:0] r;
        lo = i[3:0];
        case (i[5:4])
            2'd0:    r = lo;
            2'd1:    r = lo * 4'd5 + 4'd1;
            2'd2:    r = lo * 4'd3 + 4'd5;
            default: r = lo * 4'd7;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/md5_step.sv
// One combinational MD5 step: selects round function, message word,
// constant and rotation for step index i and produces the next A..D.
module md5_step
    import md5_pkg::*;
(
    input  logic [5:0]        i,
    input  logic [31:0]       a,
    input  logic [31:0]       b,
    input  logic [31:0]       c,
    input  logic [31:0]       d,
    input  logic [15:0][31:0] m,
    output logic [31:0]       a_n,
    output logic [31:0]       b_n,
    output logic [31:0]       c_n,
    output logic [31:0]       d_n
);

    logic [31:0] f;
    logic [31:0] sum;
    logic [63:0] rot;

    assign f   = md5_f(i[5:4], b, c, d);
    assign sum = a + f + K_TAB[i] + m[md5_g(i)];
    // Upper half of the doubled word shifted left is the left rotation.
    assign rot = {sum, sum} << S_TAB[i];

    assign a_n = d;
    assign b_n = b + rot[63:32];
    assign c_n = b;
    assign d_n = c;

endmodule

// File: rtl/md5_stream.sv
// Multi-block MD5 engine: takes pre-padded 512-bit blocks, chains H across
// blocks, runs STEPS_PER_CLK steps per cycle and hands out the digest.
module md5_stream
    import md5_pkg::*;
#(
    parameter int STEPS_PER_CLK = 1,
    parameter int BLK_W         = 512
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             blk_valid_i,
    output logic             blk_ready_o,
    input  logic [BLK_W-1:0] blk_data_i,
    input  logic             blk_last_i,
    output logic             dig_valid_o,
    input  logic             dig_ready_i,
    output logic [127:0]     dig_o,
    output logic             busy_o
);

    if (!(STEPS_PER_CLK == 1 || STEPS_PER_CLK == 2 || STEPS_PER_CLK == 4 ||
          STEPS_PER_CLK == 8 || STEPS_PER_CLK == 16)) begin : g_bad_steps
        $error("md5_stream: STEPS_PER_CLK must be 1, 2, 4, 8 or 16");
    end
    if (BLK_W != 512) begin : g_bad_blk
        $error("md5_stream: BLK_W must be 512");
    end

    localparam logic [5:0] STEP_INC = 6'(STEPS_PER_CLK);
    localparam logic [5:0] LAST_CNT = 6'(64 - STEPS_PER_CLK);

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    md5_state_e        state;
    logic [5:0]        cnt;
    logic [31:0]       h_a, h_b, h_c, h_d;
    logic [31:0]       wk_a, wk_b, wk_c, wk_d;
    logic [15:0][31:0] m_q;
    logic              last_q;

    logic [31:0] ch_a [STEPS_PER_CLK+1];
    logic [31:0] ch_b [STEPS_PER_CLK+1];
    logic [31:0] ch_c [STEPS_PER_CLK+1];
    logic [31:0] ch_d [STEPS_PER_CLK+1];

    assign ch_a[0] = wk_a;
    assign ch_b[0] = wk_b;
    assign ch_c[0] = wk_c;
    assign ch_d[0] = wk_d;

    for (genvar k = 0; k < STEPS_PER_CLK; k++) begin : g_step
        md5_step u_step (
            .i   (cnt + 6'(k)),
            .a   (ch_a[k]),
            .b   (ch_b[k]),
            .c   (ch_c[k]),
            .d   (ch_d[k]),
            .m   (m_q),
            .a_n (ch_a[k+1]),
            .b_n (ch_b[k+1]),
            .c_n (ch_c[k+1]),
            .d_n (ch_d[k+1])
        );
    end

    logic [31:0] sum_a, sum_b, sum_c, sum_d;
    assign sum_a = h_a + ch_a[STEPS_PER_CLK];
    assign sum_b = h_b + ch_b[STEPS_PER_CLK];
    assign sum_c = h_c + ch_c[STEPS_PER_CLK];
    assign sum_d = h_d + ch_d[STEPS_PER_CLK];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            h_a         <= IV_A;
            h_b         <= IV_B;
            h_c         <= IV_C;
            h_d         <= IV_D;
            blk_ready_o <= 1'b1;
            dig_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            dig_o       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (blk_valid_i && blk_ready_o) begin
                        m_q         <= blk_data_i;
                        last_q      <= blk_last_i;
                        wk_a        <= h_a;
                        wk_b        <= h_b;
                        wk_c        <= h_c;
                        wk_d        <= h_d;
                        cnt         <= '0;
                        state       <= RUN;
                        blk_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                    end
                end
                RUN: begin
                    wk_a <= ch_a[STEPS_PER_CLK];
                    wk_b <= ch_b[STEPS_PER_CLK];
                    wk_c <= ch_c[STEPS_PER_CLK];
                    wk_d <= ch_d[STEPS_PER_CLK];
                    cnt  <= cnt + STEP_INC;
                    if (cnt == LAST_CNT) begin
                        h_a    <= sum_a;
                        h_b    <= sum_b;
                        h_c    <= sum_c;
                        h_d    <= sum_d;
                        busy_o <= 1'b0;
                        if (last_q) begin
                            state       <= DONE;
                            dig_valid_o <= 1'b1;
                            dig_o       <= {bswap32(sum_a), bswap32(sum_b),
                                            bswap32(sum_c), bswap32(sum_d)};
                        end else begin
                            state       <= IDLE;
                            blk_ready_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // A block offered alongside dig_ready_i waits for IDLE.
                    if (dig_ready_i) begin
                        h_a         <= IV_A;
                        h_b         <= IV_B;
                        h_c         <= IV_C;
                        h_d         <= IV_D;
                        dig_valid_o <= 1'b0;
                        dig_o       <= '0;
                        blk_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md5_stream.sv
// Bench for md5_stream at S = 1, 4, 16 against a textbook MD5 model that
// pads strings, derives K from sin() and chains blocks itself.
module tb_md5_stream;

    localparam int NI = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] blk_data;
    logic         blk_last;
    logic         blk_valid [NI];
    logic         blk_ready [NI];
    logic         dig_valid [NI];
    logic         dig_ready [NI];
    logic         busy      [NI];
    logic [127:0] dig       [NI];

    logic [127:0] exp_dig     [NI];
    bit           exp_pending [NI];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hs_cyc = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        md5_stream #(
            .STEPS_PER_CLK (g == 0 ? 1 : (g == 1 ? 4 : 16)),
            .BLK_W         (512)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .blk_valid_i (blk_valid[g]),
            .blk_ready_o (blk_ready[g]),
            .blk_data_i  (blk_data),
            .blk_last_i  (blk_last),
            .dig_valid_o (dig_valid[g]),
            .dig_ready_i (dig_ready[g]),
            .dig_o       (dig[g]),
            .busy_o      (busy[g])
        );
    end

    function automatic int spc(input int n);
        return (n == 0) ? 1 : ((n == 1) ? 4 : 16);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] kval(input int i);
        real r;
        r = $sin(real'(i + 1));
        if (r < 0.0) r = -r;
        return 32'(longint'($floor(r * 4294967296.0)));
    endfunction

    function automatic logic [127:0] compress(input logic [127:0] hin, input logic [511:0] blk);
        int sh_tab [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
        logic [31:0] a, b, c, d, f, t;
        int g, sh;
        a = hin[127:96]; b = hin[95:64]; c = hin[63:32]; d = hin[31:0];
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0:       begin f = (b & c) | (~b & d); g = i;                end
                1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
                2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
            endcase
            sh = sh_tab[(i / 16) * 4 + (i % 4)];
            t = a + f + kval(i) + blk[32*g +: 32];
            t = (t << sh) | (t >> (32 - sh));
            a = d; d = c; c = b; b = b + t;
        end
        return {hin[127:96] + a, hin[95:64] + b, hin[63:32] + c, hin[31:0] + d};
    endfunction

    function automatic int nblk(input string s);
        return (s.len() + 8) / 64 + 1;
    endfunction

    function automatic logic [511:0] pad_block(input string s, input int bi);
        int L;
        int nb;
        logic [63:0]  bits;
        logic [511:0] r;
        L = s.len();
        nb = nblk(s);
        bits = 64'(L) * 64'd8;
        r = '0;
        for (int k = 0; k < 64; k++) begin
            int p;
            logic [7:0] by;
            p = bi * 64 + k;
            if (p < L) by = s[p];
            else if (p == L) by = 8'h80;
            else if (p >= nb * 64 - 8) by = bits[8*(p - (nb * 64 - 8)) +: 8];
            else by = 8'h00;
            r[8*k +: 8] = by;
        end
        return r;
    endfunction

    function automatic logic [31:0] bs(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [127:0] hash_str(input string s);
        logic [127:0] h;
        h = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
        for (int b = 0; b < nblk(s); b++) h = compress(h, pad_block(s, b));
        return {bs(h[127:96]), bs(h[95:64]), bs(h[63:32]), bs(h[31:0])};
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started && rst) begin
            for (int n = 0; n < NI; n++) begin
                if (dig_valid[n]) begin
                    check("cmp_expected_valid", 128'(exp_pending[n]), 128'd1);
                    check("cmp_digest", dig[n], exp_dig[n]);
                end else begin
                    check("cmp_zero_digest", dig[n], 128'd0);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (cyc > 60000) begin
            $display("FAIL watchdog: cycle %0d exceeded limit 60000", cyc);
            $fatal(1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_block(input int n, input logic [511:0] d, input logic l);
        int t = 0;
        while (!blk_ready[n] && t < 300) begin @(negedge clk); t++; end
        check("send_ready", 128'(blk_ready[n]), 128'd1);
        blk_data = d;
        blk_last = l;
        blk_valid[n] = 1'b1;
        hs_cyc = cyc;
        @(negedge clk);
        blk_valid[n] = 1'b0;
        blk_data = {16{$urandom}};
        blk_last = 1'($urandom);
        check("busy_after_hs", 128'(busy[n]), 128'd1);
    endtask

    task automatic wait_ready(input int n, input string name);
        int t = 0;
        while (!blk_ready[n] && t < 300) begin @(negedge clk); t++; end
        check({name, "_ready"}, 128'(blk_ready[n]), 128'd1);
        check({name, "_ready_lat"}, 128'(cyc - hs_cyc), 128'(64 / spc(n) + 1));
        check({name, "_no_valid"}, 128'(dig_valid[n]), 128'd0);
    endtask

    task automatic wait_digest(input int n, input logic [127:0] lit, input string name, input bit consume);
        int t = 0;
        while (!dig_valid[n] && t < 300) begin @(negedge clk); t++; end
        check({name, "_valid"}, 128'(dig_valid[n]), 128'd1);
        check({name, "_latency"}, 128'(cyc - hs_cyc), 128'(64 / spc(n) + 1));
        check({name, "_digest"}, dig[n], lit);
        if (consume) begin
            dig_ready[n] = 1'b1;
            @(negedge clk);
            dig_ready[n] = 1'b0;
            exp_pending[n] = 1'b0;
            check({name, "_valid_drop"}, 128'(dig_valid[n]), 128'd0);
            check({name, "_ready_back"}, 128'(blk_ready[n]), 128'd1);
        end
    endtask

    task automatic run_msg(input int n, input string s, input logic [127:0] lit, input string name);
        exp_dig[n] = hash_str(s);
        for (int b = 0; b < nblk(s); b++) begin
            if (b == nblk(s) - 1) exp_pending[n] = 1'b1;
            send_block(n, pad_block(s, b), 1'(b == nblk(s) - 1));
            if (b != nblk(s) - 1) wait_ready(n, name);
        end
        wait_digest(n, lit, name, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    localparam logic [127:0] D_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [127:0] D_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] D_FOX   = 128'h9e107d9d372bb6826bd81d3542a419d6;
    localparam logic [127:0] D_NUM   = 128'h57edf4a22be3c955ac49da2e2107b67a;

    initial begin
        string fox;
        string num;
        logic [511:0] abc_lit;
        fox = "The quick brown fox jumps over the lazy dog";
        num = "";
        for (int r = 0; r < 8; r++) num = {num, "1234567890"};
        abc_lit = '0;
        abc_lit[31:0]    = 32'h80636261;
        abc_lit[479:448] = 32'h00000018;

        rst = 1'b0;
        blk_data = '0;
        blk_last = 1'b0;
        for (int n = 0; n < NI; n++) begin
            blk_valid[n] = 1'b0;
            dig_ready[n] = 1'b0;
            exp_pending[n] = 1'b0;
            exp_dig[n] = '0;
        end
        repeat (3) @(negedge clk);
        for (int n = 0; n < NI; n++) begin
            check("reset_blk_ready", 128'(blk_ready[n]), 128'd1);
            check("reset_dig_valid", 128'(dig_valid[n]), 128'd0);
            check("reset_busy", 128'(busy[n]), 128'd0);
            check("reset_dig", dig[n], 128'd0);
        end
        rst = 1'b1;
        started = 1'b1;

        check("model_pad_abc", pad_block("abc", 0), abc_lit);
        check("model_empty", hash_str(""), D_EMPTY);
        check("model_abc", hash_str("abc"), D_ABC);
        check("model_fox", hash_str(fox), D_FOX);
        check("model_num", hash_str(num), D_NUM);

        run_msg(0, "", D_EMPTY, "empty_s1");
        run_msg(0, "abc", D_ABC, "abc_s1");
        run_msg(1, "abc", D_ABC, "abc_s4");
        run_msg(2, "abc", D_ABC, "abc_s16");
        run_msg(0, fox, D_FOX, "fox_s1");
        run_msg(0, num, D_NUM, "num_s1");
        run_msg(2, num, D_NUM, "num_s16");

        // Back-pressure, then digest release and new block offered together.
        exp_dig[0] = hash_str("abc");
        exp_pending[0] = 1'b1;
        send_block(0, abc_lit, 1'b1);
        wait_digest(0, D_ABC, "bp_first", 1'b0);
        repeat (20) begin
            @(negedge clk);
            check("bp_hold_digest", dig[0], D_ABC);
            check("bp_hold_valid", 128'(dig_valid[0]), 128'd1);
            check("bp_hold_blk_ready", 128'(blk_ready[0]), 128'd0);
        end
        dig_ready[0] = 1'b1;
        blk_valid[0] = 1'b1;
        blk_data = abc_lit;
        blk_last = 1'b1;
        @(negedge clk);
        dig_ready[0] = 1'b0;
        check("bp_release_valid", 128'(dig_valid[0]), 128'd0);
        check("bp_release_idle_ready", 128'(blk_ready[0]), 128'd1);
        check("bp_release_not_busy", 128'(busy[0]), 128'd0);
        hs_cyc = cyc;
        @(negedge clk);
        blk_valid[0] = 1'b0;
        check("bp_second_busy", 128'(busy[0]), 128'd1);
        check("bp_second_blk_ready", 128'(blk_ready[0]), 128'd0);
        wait_digest(0, D_ABC, "bp_second", 1'b1);

        // Abort block 0 of the two-block message with a mid-RUN reset.
        exp_pending[0] = 1'b0;
        send_block(0, pad_block(num, 0), 1'b0);
        repeat (28) @(negedge clk);
        check("abort_busy_before", 128'(busy[0]), 128'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_blk_ready", 128'(blk_ready[0]), 128'd1);
        check("abort_busy", 128'(busy[0]), 128'd0);
        check("abort_dig_valid", 128'(dig_valid[0]), 128'd0);
        repeat (70) begin
            @(negedge clk);
            if (dig_valid[0]) check("abort_stale_valid", 128'(dig_valid[0]), 128'd0);
        end
        run_msg(0, "abc", D_ABC, "abc_after_abort");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
